// File: rtl/handshake_cond_br_fifo.sv
// Conditional branch with a registered join FIFO: joins {condition, data}, buffers
// DEPTH pairs, and steers the head token to trueOut or falseOut by its stored condition.
module handshake_cond_br_fifo #(
   parameter int DATA_TYPE = 32,
   parameter int DEPTH     = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 condition,
   input  logic                 condition_valid,
   output logic                 condition_ready,
   input  logic [DATA_TYPE-1:0] data,
   input  logic                 data_valid,
   output logic                 data_ready,
   output logic [DATA_TYPE-1:0] trueOut,
   output logic                 trueOut_valid,
   input  logic                 trueOut_ready,
   output logic [DATA_TYPE-1:0] falseOut,
   output logic                 falseOut_valid,
   input  logic                 falseOut_ready
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic                 cond;
      logic [DATA_TYPE-1:0] data;
   } entry_t;

   entry_t        mem [DEPTH];
   logic [PW-1:0] wp;
   logic [PW-1:0] rp;
   logic [CW-1:0] count;

   logic   full;
   logic   empty;
   logic   push;
   logic   pop;
   entry_t head;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rp];

   // Readies look only at the partner valid and registered full, never at the sinks.
   assign condition_ready = rst & data_valid & ~full;
   assign data_ready      = rst & condition_valid & ~full;
   assign push            = condition_valid & condition_ready;

   assign trueOut_valid  = ~empty & head.cond;
   assign falseOut_valid = ~empty & ~head.cond;
   assign trueOut        = head.data;
   assign falseOut       = head.data;

   assign pop = (trueOut_valid & trueOut_ready) | (falseOut_valid & falseOut_ready);

   always_ff @(posedge clk) begin
      if (!rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wp] <= '{cond: condition, data: data};
            wp      <= ptr_inc(wp);
         end
         if (pop) rp <= ptr_inc(rp);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

endmodule

// File: tb/tb_handshake_cond_br_fifo.sv
// Bench for handshake_cond_br_fifo: DEPTH=2 and DEPTH=3 instances share stimulus,
// each checked every cycle against its own token queue.
module tb_handshake_cond_br_fifo;

   logic        clk;
   logic        rst;
   logic        cond;
   logic        cv;
   logic        dv;
   logic [31:0] data;
   logic        tr;
   logic        fr;

   logic [1:0]  c_rdy;
   logic [1:0]  d_rdy;
   logic [1:0]  t_vld;
   logic [1:0]  f_vld;
   logic [31:0] t_dat [2];
   logic [31:0] f_dat [2];

   int checks = 0;
   int errors = 0;

   typedef logic [32:0] q_t [$];
   q_t mq [2];
   bit fresh [2];
   bit push_m [2];
   bit pop_m [2];

   handshake_cond_br_fifo #(.DATA_TYPE(32), .DEPTH(2)) u2 (
      .clk(clk), .rst(rst),
      .condition(cond), .condition_valid(cv), .condition_ready(c_rdy[0]),
      .data(data), .data_valid(dv), .data_ready(d_rdy[0]),
      .trueOut(t_dat[0]), .trueOut_valid(t_vld[0]), .trueOut_ready(tr),
      .falseOut(f_dat[0]), .falseOut_valid(f_vld[0]), .falseOut_ready(fr)
   );

   handshake_cond_br_fifo #(.DATA_TYPE(32), .DEPTH(3)) u3 (
      .clk(clk), .rst(rst),
      .condition(cond), .condition_valid(cv), .condition_ready(c_rdy[1]),
      .data(data), .data_valid(dv), .data_ready(d_rdy[1]),
      .trueOut(t_dat[1]), .trueOut_valid(t_vld[1]), .trueOut_ready(tr),
      .falseOut(f_dat[1]), .falseOut_valid(f_vld[1]), .falseOut_ready(fr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: compare every output at the falling edge, then advance the queues.
   task automatic tick();
      int          dep;
      int          sz;
      logic        full;
      logic        etv;
      logic        efv;
      logic [31:0] cnt;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         dep  = (i == 0) ? 2 : 3;
         sz   = mq[i].size();
         full = (sz == dep);
         etv  = (sz != 0) && mq[i][0][32];
         efv  = (sz != 0) && !mq[i][0][32];
         cnt  = (i == 0) ? 32'(u2.count) : 32'(u3.count);
         chk($sformatf("cond_ready d%0d", dep), 32'(c_rdy[i]), 32'(rst & dv & ~full));
         chk($sformatf("data_ready d%0d", dep), 32'(d_rdy[i]), 32'(rst & cv & ~full));
         chk($sformatf("true_valid d%0d", dep), 32'(t_vld[i]), 32'(etv));
         chk($sformatf("false_valid d%0d", dep), 32'(f_vld[i]), 32'(efv));
         chk($sformatf("count d%0d", dep), cnt, 32'(sz));
         if (sz != 0) begin
            chk($sformatf("true_data d%0d", dep), t_dat[i], mq[i][0][31:0]);
            chk($sformatf("false_data d%0d", dep), f_dat[i], mq[i][0][31:0]);
         end else if (fresh[i]) begin
            chk($sformatf("true_zero d%0d", dep), t_dat[i], 32'h0);
            chk($sformatf("false_zero d%0d", dep), f_dat[i], 32'h0);
         end
         push_m[i] = cv & dv & ~full & rst;
         pop_m[i]  = (etv & tr) | (efv & fr);
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (!rst) begin
            mq[i].delete();
            fresh[i] = 1'b1;
         end else begin
            if (pop_m[i]) void'(mq[i].pop_front());
            if (push_m[i]) begin
               mq[i].push_back({cond, data});
               fresh[i] = 1'b0;
            end
         end
      end
      #1;
   endtask

   // Present one token until the DEPTH=3 instance takes it.
   task automatic send(input logic c, input logic [31:0] d);
      cond = c; data = d; cv = 1'b1; dv = 1'b1;
      for (int n = 0; n < 40; n++) begin
         tick();
         if (push_m[1]) return;
      end
      checks++;
      errors++;
      $error("FAIL send_timeout: observed no accept expected accept of %h", d);
   endtask

   task automatic idle(input int n);
      cv = 1'b0; dv = 1'b0;
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      int idx;
      logic [4:0] hol_cond;
      rst = 1'b0; cond = 1'b0; cv = 1'b0; dv = 1'b0; data = '0; tr = 1'b0; fr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         mq[i].delete();
         fresh[i] = 1'b1;
      end
      rst = 1'b1;

      // reset state
      idle(2);

      // routing
      tr = 1'b1; fr = 1'b1;
      cv = 1'b1; dv = 1'b1;
      cond = 1'b1; data = 32'h0000_0005; tick();
      cond = 1'b0; data = 32'hFFFF_FFFB; tick();
      idle(3);

      // join stall
      cv = 1'b1; dv = 1'b0; cond = 1'b1; data = 32'h0000_00C3;
      repeat (3) tick();
      dv = 1'b1; tick();
      idle(2);

      // full backpressure
      tr = 1'b0; fr = 1'b0; cond = 1'b1; cv = 1'b1; dv = 1'b1;
      data = 32'hA; tick();
      data = 32'hB; tick();
      data = 32'hC; tick();
      tr = 1'b1; tick();
      tr = 1'b0; tick();
      tr = 1'b1; fr = 1'b1;
      idle(6);

      // head-of-line blocking with pointer wrap on DEPTH=3
      hol_cond = 5'b10101;
      tr = 1'b1; fr = 1'b0; idx = 0;
      for (int k = 0; k < 40 && idx < 5; k++) begin
         if (k == 4) fr = 1'b1;
         cond = hol_cond[idx]; data = 32'h100 + 32'(idx); cv = 1'b1; dv = 1'b1;
         tick();
         if (push_m[1]) idx++;
      end
      fr = 1'b1;
      idle(6);

      // mid-flight reset
      tr = 1'b0; fr = 1'b0;
      send(1'b1, 32'hA1);
      send(1'b0, 32'hA2);
      cond = 1'b1; data = 32'hA3; cv = 1'b1; dv = 1'b1;
      rst = 1'b0; tick();
      rst = 1'b1; idle(1);
      tr = 1'b1; fr = 1'b1;
      send(1'b0, 32'h77);
      idle(3);

      // randomized traffic
      for (int k = 0; k < 600; k++) begin
         cv   = ($urandom_range(0, 3) != 0);
         dv   = ($urandom_range(0, 3) != 0);
         cond = 1'($urandom);
         data = $urandom;
         tr   = ($urandom_range(0, 3) != 0);
         fr   = ($urandom_range(0, 2) != 0);
         rst  = ($urandom_range(0, 149) != 0);
         tick();
      end
      rst = 1'b1; tr = 1'b1; fr = 1'b1;
      idle(6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
